// File: rtl/i2s_mic_window.sv
// i2s_mic_window: I2S microphone receiver feeding an offset-calibrated, saturating sample window
//   clk, reset        : system clock, asynchronous active-high reset
//   en                : capture enable; low parks BCLK=0/LRCLK=1 and drops any partial sample
//   flush             : synchronous clear of window and fill (serial timing keeps running)
//   DOUT              : serial microphone data, sampled in BCLK rise cycles
//   BCLK, LRCLK       : registered bit clock and word select (0=left, 1=right)
//   window            : DEPTH signed samples, slice 0 newest
//   new_t, new_ch     : one-cycle push strobe and channel of the pushed sample
//   fill, window_full : saturating count of valid samples and its full flag
module i2s_mic_window #(
    parameter int SAMPLE_BITS  = 18,
    parameter int SLOT_BITS    = 32,
    parameter int DEPTH        = 16,
    parameter int BCLK_DIV     = 1,
    parameter int CAL_OFFSET   = 7424,
    parameter int CHANNEL_MODE = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic                            flush,
    input  logic                            DOUT,
    output logic                            BCLK,
    output logic                            LRCLK,
    output logic [DEPTH*SAMPLE_BITS-1:0]    window,
    output logic                            new_t,
    output logic                            new_ch,
    output logic [$clog2(DEPTH+1)-1:0]      fill,
    output logic                            window_full
);
    localparam int DW = $clog2(BCLK_DIV + 1);
    localparam int BW = $clog2(SLOT_BITS);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(SLOT_BITS - 1);
    localparam logic [BW-1:0] B_SAMP = BW'(SAMPLE_BITS);
    localparam logic signed [SAMPLE_BITS:0] CAL = (SAMPLE_BITS + 1)'(CAL_OFFSET);

    logic [DW-1:0]            div_cnt;
    logic [BW-1:0]            bit_idx;
    logic                     lr_due;
    logic [SAMPLE_BITS-2:0]   shreg;
    logic                     edge_now, rise, fall, capture, selected, push;
    logic [SAMPLE_BITS-1:0]   raw, sat;
    logic signed [SAMPLE_BITS:0] sum;

    // raw already includes the bit arriving this cycle, so the b=SAMPLE_BITS
    // rise cycle can push the finished sample at its closing edge.
    always_comb begin
        edge_now    = en && div_cnt == DIV_LAST;
        rise        = edge_now && !BCLK;
        fall        = edge_now && BCLK;
        capture     = rise && bit_idx != '0 && bit_idx <= B_SAMP;
        raw         = {shreg, DOUT};
        sum         = $signed({raw[SAMPLE_BITS-1], raw}) + CAL;
        sat         = (sum[SAMPLE_BITS] ^ sum[SAMPLE_BITS-1])
                    ? {sum[SAMPLE_BITS], {(SAMPLE_BITS-1){~sum[SAMPLE_BITS]}}}
                    : sum[SAMPLE_BITS-1:0];
        selected    = CHANNEL_MODE == 2 || LRCLK == (CHANNEL_MODE == 1);
        push        = rise && bit_idx == B_SAMP && selected && !flush;
        window_full = fill == FW'(DEPTH);
    end

    // Serial timing: lr_due remembers that the last slot bit has been clocked,
    // so LRCLK flips on the following BCLK fall rather than on the rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            BCLK    <= 1'b0;
            LRCLK   <= 1'b1;
            div_cnt <= '0;
            bit_idx <= '0;
            lr_due  <= 1'b0;
            shreg   <= '0;
        end else if (!en) begin
            BCLK    <= 1'b0;
            LRCLK   <= 1'b1;
            div_cnt <= '0;
            bit_idx <= '0;
            lr_due  <= 1'b0;
            shreg   <= '0;
        end else begin
            div_cnt <= edge_now ? '0 : div_cnt + DW'(1);
            if (edge_now)
                BCLK <= ~BCLK;
            if (rise) begin
                bit_idx <= bit_idx == B_LAST ? '0 : bit_idx + BW'(1);
                lr_due  <= bit_idx == B_LAST;
            end
            if (capture)
                shreg <= raw[SAMPLE_BITS-2:0];
            if (fall && lr_due) begin
                LRCLK  <= ~LRCLK;
                lr_due <= 1'b0;
            end
        end
    end

    // Window and fill survive en=0; only reset and flush clear them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window <= '0;
            fill   <= '0;
            new_t  <= 1'b0;
            new_ch <= 1'b0;
        end else begin
            new_t <= push;
            if (push)
                new_ch <= LRCLK;
            if (flush) begin
                window <= '0;
                fill   <= '0;
            end else if (push) begin
                window <= {window[(DEPTH-1)*SAMPLE_BITS-1:0], sat};
                fill   <= fill == FW'(DEPTH) ? fill : fill + FW'(1);
            end
        end
    end
endmodule

// File: tb/tb_i2s_mic_window.sv
// tb_i2s_mic_window: directed, table-driven bench for i2s_mic_window (four parameter variants)
module tb_i2s_mic_window;
    localparam int SB = 18;
    localparam int WW = 16 * SB;

    typedef struct {
        logic [SB-1:0] raw;
        logic [SB-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic DOUT = 1'b0;
    logic [3:0] en = '0;
    logic [3:0] bclk, lrclk, new_t, new_ch, full;
    logic [WW-1:0] win [4];
    logic [4:0] fill [4];

    int tests = 0, fails = 0, tmis = 0, n = 0, cur = 0, c = 0, pc = 0;
    int hdiv [4] = '{1, 1, 1, 3};
    int sv [64];
    logic [WW-1:0] mw;
    vec_t vt [9];

    always #5 clk = ~clk;

    i2s_mic_window u0 (.clk(clk), .reset(reset), .en(en[0]), .flush(flush), .DOUT(DOUT),
        .BCLK(bclk[0]), .LRCLK(lrclk[0]), .window(win[0]), .new_t(new_t[0]), .new_ch(new_ch[0]),
        .fill(fill[0]), .window_full(full[0]));
    i2s_mic_window #(.CAL_OFFSET(0)) u1 (.clk(clk), .reset(reset), .en(en[1]), .flush(flush),
        .DOUT(DOUT), .BCLK(bclk[1]), .LRCLK(lrclk[1]), .window(win[1]), .new_t(new_t[1]),
        .new_ch(new_ch[1]), .fill(fill[1]), .window_full(full[1]));
    i2s_mic_window #(.CAL_OFFSET(0), .CHANNEL_MODE(2)) u2 (.clk(clk), .reset(reset), .en(en[2]),
        .flush(flush), .DOUT(DOUT), .BCLK(bclk[2]), .LRCLK(lrclk[2]), .window(win[2]),
        .new_t(new_t[2]), .new_ch(new_ch[2]), .fill(fill[2]), .window_full(full[2]));
    i2s_mic_window #(.BCLK_DIV(3)) u3 (.clk(clk), .reset(reset), .en(en[3]), .flush(flush),
        .DOUT(DOUT), .BCLK(bclk[3]), .LRCLK(lrclk[3]), .window(win[3]), .new_t(new_t[3]),
        .new_ch(new_ch[3]), .fill(fill[3]), .window_full(full[3]));

    // Serial bit presented in cycle t after enable: rise k sits in [2Hk, 2Hk+2H-1],
    // slot k/32 (even=right), bits b=1..18 carry the sample MSB first.
    function automatic logic dout_bit(int t);
        int h, k, slot, b;
        logic [31:0] v;
        h = hdiv[cur];
        k = t / (2 * h);
        slot = k / 32;
        b = k % 32;
        if (slot > 63 || b < 1 || b > SB) return 1'b0;
        v = sv[slot];
        return v[SB - b];
    endfunction

    task automatic chk(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic was_en;
        was_en = en[cur];
        DOUT = dout_bit(n);
        @(posedge clk);
        #1;
        n++;
        if (was_en ? (bclk[cur] !== 1'((n / hdiv[cur]) % 2) ||
                      lrclk[cur] !== 1'(1 ^ ((n / (64 * hdiv[cur])) % 2)))
                   : (bclk[cur] !== 1'b0 || lrclk[cur] !== 1'b1))
            tmis++;
    endtask

    task automatic start(int i);
        cur = i;
        en[i] = 1'b1;
        n = 0;
    endtask

    task automatic wait_push(int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (new_t[cur] !== 1'b1 && cyc < budget);
    endtask

    task automatic model_push(logic [SB-1:0] v);
        mw = {mw[WW-SB-1:0], v};
    endtask

    task automatic idle_ticks(int k);
        for (int i = 0; i < k; i++) begin
            tick();
            if (new_t[cur] === 1'b1) pc++;
        end
    endtask

    initial begin
        vt[0] = '{18'h00000, 18'h01D00};
        vt[1] = '{18'h1FFFF, 18'h1FFFF};
        vt[2] = '{18'h20000, 18'h21D00};
        vt[3] = '{18'h1E2FF, 18'h1FFFF};
        vt[4] = '{18'h1E300, 18'h1FFFF};
        vt[5] = '{18'h3FFFF, 18'h01CFF};
        vt[6] = '{18'h3E300, 18'h00000};
        vt[7] = '{18'h12345, 18'h14045};
        vt[8] = '{18'h20001, 18'h21D01};

        #12;
        for (int i = 0; i < 4; i++) begin
            chk("reset bclk", WW'(bclk[i]), 0);
            chk("reset lrclk", WW'(lrclk[i]), 1);
            chk("reset window", win[i], 0);
            chk("reset fill", WW'(fill[i]), 0);
            chk("reset full", WW'(full[i]), 0);
            chk("reset new_t", WW'(new_t[i]), 0);
            chk("reset new_ch", WW'(new_ch[i]), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Defaults: calibrated, saturating left-only capture, one push per 128-clk frame
        for (int s = 0; s < 64; s++) sv[s] = 32'h2AAAA;
        for (int f = 0; f < 9; f++) sv[2 * f + 1] = int'(vt[f].raw);
        mw = '0;
        tmis = 0;
        start(0);
        for (int f = 0; f < 9; f++) begin
            wait_push(200, c);
            chk("A push spacing", WW'(c), WW'(f == 0 ? 101 : 127));
            chk("A new_ch", WW'(new_ch[0]), 0);
            chk("A slice0", WW'(win[0][SB-1:0]), WW'(vt[f].exp));
            chk("A fill", WW'(fill[0]), WW'(f + 1));
            model_push(vt[f].exp);
            tick();
            chk("A new_t single pulse", WW'(new_t[0]), 0);
        end
        chk("A window", win[0], mw);

        // Abort at left b=9, idle 20 clk, restart from a fresh frame
        en[0] = 1'b0;
        idle_ticks(5);
        for (int s = 0; s < 64; s++) sv[s] = 0;
        sv[1] = 32'h0ABCD;
        pc = 0;
        start(0);
        idle_ticks(83);
        en[0] = 1'b0;
        idle_ticks(20);
        chk("abort no new_t", WW'(pc), 0);
        chk("abort bclk idle", WW'(bclk[0]), 0);
        chk("abort lrclk idle", WW'(lrclk[0]), 1);
        chk("abort window kept", win[0], mw);
        sv[1] = 32'h00123;
        start(0);
        wait_push(200, c);
        chk("restart push spacing", WW'(c), 101);
        chk("restart slice0", WW'(win[0][SB-1:0]), WW'(18'h01E23));
        model_push(18'h01E23);
        chk("restart window", win[0], mw);
        chk("restart fill", WW'(fill[0]), 10);
        chk("A timing", WW'(tmis), 0);
        en[0] = 1'b0;
        tick();

        // 17 raw pushes into a 16-deep window
        for (int s = 0; s < 64; s++) sv[s] = 32'h3FFFF;
        for (int f = 0; f < 17; f++) sv[2 * f + 1] = f + 1;
        tmis = 0;
        start(1);
        for (int f = 0; f < 17; f++) begin
            wait_push(200, c);
            chk("B push spacing", WW'(c), WW'(f == 0 ? 101 : 128));
            if (f == 14) begin
                chk("B fill 15", WW'(fill[1]), 15);
                chk("B not full at 15", WW'(full[1]), 0);
            end
        end
        chk("B slice0", WW'(win[1][0 +: SB]), 17);
        chk("B slice15", WW'(win[1][15 * SB +: SB]), 2);
        chk("B fill sat", WW'(fill[1]), 16);
        chk("B full", WW'(full[1]), 1);
        chk("B timing", WW'(tmis), 0);

        // Reset mid-sample discards it; capture restarts on the next enabled cycle
        en[1] = 1'b0;
        tick();
        start(1);
        idle_ticks(90);
        reset = 1'b1;
        #2;
        chk("async reset bclk", WW'(bclk[1]), 0);
        chk("async reset lrclk", WW'(lrclk[1]), 1);
        chk("async reset window", win[1], 0);
        chk("async reset fill", WW'(fill[1]), 0);
        reset = 1'b0;
        n = 0;
        tmis = 0;
        wait_push(200, c);
        chk("post reset spacing", WW'(c), 101);
        chk("post reset window", win[1], WW'(1));
        chk("post reset fill", WW'(fill[1]), 1);
        chk("post reset timing", WW'(tmis), 0);
        en[1] = 1'b0;
        tick();

        // Interleaved channels: right first, then left, 64 clk apart
        for (int s = 0; s < 64; s++) sv[s] = 32'h100 + s;
        mw = '0;
        tmis = 0;
        start(2);
        for (int s = 0; s < 4; s++) begin
            wait_push(200, c);
            chk("C push spacing", WW'(c), WW'(s == 0 ? 37 : 64));
            chk("C new_ch", WW'(new_ch[2]), WW'((s + 1) % 2));
            chk("C slice0", WW'(win[2][SB-1:0]), WW'(32'h100 + s));
            model_push(SB'(32'h100 + s));
        end
        chk("C window", win[2], mw);
        chk("C timing", WW'(tmis), 0);
        en[2] = 1'b0;
        tick();

        // BCLK_DIV=3: 384-clk frame, flush in the push cycle drops that push
        for (int s = 0; s < 64; s++) sv[s] = 0;
        sv[1] = 32'h10;
        sv[3] = 32'h20;
        sv[5] = 32'h30;
        tmis = 0;
        pc = 0;
        start(3);
        wait_push(500, c);
        chk("D first push", WW'(c), 303);
        chk("D slice0", WW'(win[3][SB-1:0]), WW'(18'h01D10));
        chk("D fill", WW'(fill[3]), 1);
        idle_ticks(686 - n);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush new_t", WW'(new_t[3]), 0);
        chk("flush window", win[3], 0);
        chk("flush fill", WW'(fill[3]), 0);
        chk("flush full", WW'(full[3]), 0);
        chk("flush no stray push", WW'(pc), 0);
        wait_push(500, c);
        chk("D frame spacing", WW'(c), 384);
        chk("D after flush window", win[3], WW'(18'h01D30));
        chk("D after flush fill", WW'(fill[3]), 1);
        chk("D timing", WW'(tmis), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/i2s_mic_window.md
I2S_MIC_WINDOW -- requirements
Module: i2s_mic_window

Interface
REQ-001 SHALL have parameter SAMPLE_BITS, default 18, meaning signed sample width captured per slot (8..SLOT_BITS-1).
REQ-002 SHALL have parameter SLOT_BITS, default 32, meaning BCLK periods per LRCLK half-frame.
REQ-003 SHALL have parameter DEPTH, default 16, meaning number of samples held in the output window (2..64).
REQ-004 SHALL have parameter BCLK_DIV, default 1, meaning BCLK half-period in clk cycles (>=1).
REQ-005 SHALL have parameter CAL_OFFSET, default 7424, meaning signed DC offset added to every captured sample.
REQ-006 SHALL have parameter CHANNEL_MODE, default 0, meaning 0=left only, 1=right only, 2=both channels interleaved.
REQ-007 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port en  input  1  capture enable.
REQ-010 SHALL have port flush  input  1  synchronous clear of window contents and fill count.
REQ-011 SHALL have port DOUT  input  1  serial data from microphone.
REQ-012 SHALL have port BCLK  output  1  registered bit clock to microphone.
REQ-013 SHALL have port LRCLK  output  1  registered word select; 0=left, 1=right.
REQ-014 SHALL have port window  output  DEPTH*SAMPLE_BITS  flattened samples; slice k (bits k*SAMPLE_BITS+:SAMPLE_BITS) is sample k, k=0 newest.
REQ-015 SHALL have port new_t  output  1  one-cycle pulse when a sample is pushed.
REQ-016 SHALL have port new_ch  output  1  channel of the pushed sample (0=left, 1=right), valid with new_t.
REQ-017 SHALL have port fill  output  $clog2(DEPTH+1)  number of valid samples in window, saturating at DEPTH.
REQ-018 SHALL have port window_full  output  1  high when fill==DEPTH.

Function
REQ-019 SHALL, while en=1, toggle BCLK every BCLK_DIV clk cycles; a "rise cycle" is the clk cycle in which BCLK goes 0->1.
REQ-020 SHALL count slot bit index b=0..SLOT_BITS-1 on rise cycles, b=0 on the first rise after an LRCLK change.
REQ-021 SHALL toggle LRCLK on the BCLK falling edge following the rise with b=SLOT_BITS-1, then restart b at 0.
REQ-022 SHALL ignore DOUT at b=0 (I2S one-bit delay) and shift DOUT in MSB-first on rise cycles b=1..SAMPLE_BITS.
REQ-023 SHALL ignore DOUT for b>SAMPLE_BITS.
REQ-024 SHALL, one clk after the rise cycle of b=SAMPLE_BITS, push the sample if the current slot is selected by CHANNEL_MODE, asserting new_t for exactly one cycle and new_ch=LRCLK.
REQ-025 SHALL compute pushed value as raw signed + CAL_OFFSET in SAMPLE_BITS+1 bits, saturated to [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1].
REQ-026 SHALL on push shift slice k-1 into slice k for k=DEPTH-1..1, discard old slice DEPTH-1, and load slice 0 with the pushed value.
REQ-027 SHALL increment fill on push until DEPTH, then hold at DEPTH.
REQ-028 SHALL, when en=0, hold BCLK=0 and LRCLK=1, reset b and the shift register, discard any partial sample, and retain window and fill.
REQ-029 SHALL, on en 0->1, start a new frame with LRCLK=1 (right slot first), first rise at b=0.
REQ-030 SHALL on flush=1 zero window and fill in the next cycle; a push in the same cycle is dropped and new_t stays 0.
REQ-031 SHALL keep the serial timing (BCLK, LRCLK, b) unaffected by flush.

Reset
REQ-032 SHALL on reset=1 immediately force BCLK=0, LRCLK=1, b=0, shift register=0, window=0, fill=0, window_full=0, new_t=0, new_ch=0.
REQ-033 SHALL resume from REQ-029 frame start on the first en=1 cycle after reset deasserts; reset mid-sample discards that sample.

Verification
REQ-034 SHALL verify defaults, en=1, left slot DOUT=all zeros: after the first left sample new_t pulses once, new_ch=0, slice 0=7424, fill=1, 128 clk per frame.
REQ-035 SHALL verify saturation: left raw 0x1FFFF -> slice 0=0x1FFFF; raw 0x20000 -> slice 0=0x21D00.
REQ-036 SHALL verify 17 consecutive left pushes of values 1..17 (raw, CAL_OFFSET=0): slice 0=17, slice 15=2, fill=16, window_full=1.
REQ-037 SHALL verify CHANNEL_MODE=2: pushes alternate new_ch=1 then 0, two new_t per frame spaced 64 clk apart.
REQ-038 SHALL verify en dropped at b=9, raised 20 clk later: no new_t for the aborted slot, BCLK=0/LRCLK=1 while low, window unchanged.
REQ-039 SHALL verify flush coincident with new_t cycle: window=0, fill=0, new_t=0; with BCLK_DIV=3, BCLK period=6 clk, frame=384 clk.
